// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard sequencer.
// Used by pipe_hazard_ctrl and haz_md_timer.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'b00,
        HZ_MD_WAIT = 2'b01,
        HZ_MD_DONE = 2'b10
    } hzState_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Wide enough for the largest legal MULT/DIV latency (15).
    localparam int MD_CNT_W = 4;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic loadUse(
        input logic       mem2r,
        input logic       regw,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       usesRt
    );
        return mem2r & regw & (rd != REG_ZERO) &
               ((rd == rs) | (usesRt & (rd == rt)));
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard sequencer signal bundle. The pipeline side is the
// master (drives ID/EX decode info), the sequencer is the slave.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_md_start;
    logic             ex_mem2r;
    logic             ex_regw;
    logic [4:0]       ex_rd;
    logic [1:0]       ex_pcsel;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_busy;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_md_start,
        output ex_mem2r, ex_regw, ex_rd, ex_pcsel,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
        input  md_busy, hz_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_md_start,
        input  ex_mem2r, ex_regw, ex_rd, ex_pcsel,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble,
        output md_busy, hz_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/haz_md_timer.sv
// Loadable down-counter for MULT/DIV occupancy; done is high while the
// count sits at 1, i.e. during the last wait cycle.
module haz_md_timer
    import hazard_pkg::*;
#(
    parameter int W = MD_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic         clr,
    input  logic [W-1:0] loadVal,
    output logic         done
);

    logic [W-1:0] cnt;

    // Abort clear beats a new load, which beats counting down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer: load-use stalls, redirect squash and MULT/DIV wait FSM.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);

    hzState_t state;
    hzState_t nextState;

    logic lu;
    logic redirect;
    logic tmrLoad;
    logic tmrDec;
    logic tmrClr;
    logic tmrDone;

    logic pcStall;
    logic ifidStall;
    logic ifidFlush;
    logic idexBubble;
    logic mdBusy;

    assign lu       = loadUse(hz.ex_mem2r, hz.ex_regw, hz.ex_rd,
                              hz.id_rs, hz.id_rt, hz.id_uses_rt);
    assign redirect = (hz.ex_pcsel != PCSEL_SEQ);

    haz_md_timer #(
        .W       (MD_CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmrLoad),
        .dec     (tmrDec),
        .clr     (tmrClr),
        .loadVal (MD_LOAD),
        .done    (tmrDone)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HZ_RUN;
        end else begin
            state <= nextState;
        end
    end

    // Controls are combinational so they act in the cycle the hazard is seen;
    // holding rst low forces every control low regardless of the inputs.
    always_comb begin
        nextState  = state;
        pcStall    = 1'b0;
        ifidStall  = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        mdBusy     = 1'b0;
        tmrLoad    = 1'b0;
        tmrDec     = 1'b0;
        tmrClr     = 1'b0;
        if (rst) begin
            case (state)
                HZ_RUN: begin
                    if (redirect) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (lu) begin
                        pcStall    = 1'b1;
                        ifidStall  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (hz.id_md_start) begin
                        nextState = HZ_MD_WAIT;
                        tmrLoad   = 1'b1;
                    end
                end
                HZ_MD_WAIT: begin
                    mdBusy = 1'b1;
                    if (redirect) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                        tmrClr     = 1'b1;
                        nextState  = HZ_RUN;
                    end else begin
                        pcStall    = 1'b1;
                        ifidStall  = 1'b1;
                        idexBubble = 1'b1;
                        tmrDec     = 1'b1;
                        if (tmrDone) begin
                            nextState = HZ_MD_DONE;
                        end
                    end
                end
                HZ_MD_DONE: begin
                    // The MULT/DIV issues now; a new one must pass through RUN first.
                    mdBusy    = 1'b1;
                    nextState = HZ_RUN;
                    if (redirect) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                        tmrClr     = 1'b1;
                    end else if (lu) begin
                        pcStall    = 1'b1;
                        ifidStall  = 1'b1;
                        idexBubble = 1'b1;
                    end
                end
                default: begin
                    nextState = HZ_RUN;
                    tmrClr    = 1'b1;
                end
            endcase
        end
    end

    assign hz.pc_stall    = pcStall;
    assign hz.ifid_stall  = ifidStall;
    assign hz.ifid_flush  = ifidFlush;
    assign hz.idex_bubble = idexBubble;
    assign hz.md_busy     = mdBusy;
    assign hz.hz_state    = state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Saturate at all-ones; only rst clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (pcStall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (ifidFlush && (flushCnt != '1)) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign hz.stall_cnt = stallCnt;
    assign hz.flush_cnt = flushCnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MD_LAT=4); expected control
// vectors are queued per cycle and compared on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;

    // Expected vector layout: {pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy, hz_state}
    localparam logic [6:0] IDLE      = 7'b0000000;
    localparam logic [6:0] LU        = 7'b1101000;
    localparam logic [6:0] FLUSH_RUN = 7'b0011000;
    localparam logic [6:0] MDW       = 7'b1101101;
    localparam logic [6:0] MDD       = 7'b0000110;
    localparam logic [6:0] FLUSH_MDW = 7'b0011101;
    localparam logic [6:0] FLUSH_MDD = 7'b0011110;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       mdStart;
        logic       mem2r;
        logic       regw;
        logic [4:0] rd;
        logic [1:0] pcsel;
    } stimT;

    logic clk;
    logic rst;

    int checks;
    int errors;
    logic [CNT_W-1:0] expStall;
    logic [CNT_W-1:0] expFlush;
    logic [6:0] expQ[$];

    hazard_if #(.CNT_W(CNT_W)) hif ();

    pipe_hazard_ctrl #(
        .MD_LAT (4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver ----------------
    function automatic stimT mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic usesRt, input logic mdStart,
                                input logic mem2r, input logic regw,
                                input logic [4:0] rd, input logic [1:0] pcsel);
        stimT s;
        s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.mdStart = mdStart;
        s.mem2r = mem2r; s.regw = regw; s.rd = rd; s.pcsel = pcsel;
        return s;
    endfunction

    task automatic apply(input stimT s);
        hif.id_rs       = s.rs;
        hif.id_rt       = s.rt;
        hif.id_uses_rt  = s.usesRt;
        hif.id_md_start = s.mdStart;
        hif.ex_mem2r    = s.mem2r;
        hif.ex_regw     = s.regw;
        hif.ex_rd       = s.rd;
        hif.ex_pcsel    = s.pcsel;
    endtask

    task automatic drive(input stimT s);
        @(posedge clk);
        #1;
        apply(s);
    endtask

    task automatic tally(input logic [6:0] v);
        expStall = expStall + {{(CNT_W-1){1'b0}}, v[6]};
        expFlush = expFlush + {{(CNT_W-1){1'b0}}, v[4]};
    endtask

    function automatic logic [6:0] observed();
        return {hif.pc_stall, hif.ifid_stall, hif.ifid_flush, hif.idex_bubble,
                hif.md_busy, hif.hz_state};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b0;
        expStall = '0;
        expFlush = '0;
        // Hazard-looking inputs while in reset must not leak to the controls.
        apply(mk(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 2'b01));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, IDLE);
        end
        checks++;
        if ((hif.stall_cnt !== '0) || (hif.flush_cnt !== '0)) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", hif.stall_cnt, hif.flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== IDLE) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", got, IDLE);
        end
    endtask

    task automatic test_load_use();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00)); e.push_back(LU);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00)); e.push_back(IDLE);
        s.push_back(mk(5'd7, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 2'b00)); e.push_back(LU);
        s.push_back(mk(5'd7, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 2'b00)); e.push_back(IDLE);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 2'b00)); e.push_back(IDLE);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 2'b00)); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_rd_zero();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        s.push_back(mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 2'b00)); e.push_back(IDLE);
        s.push_back(mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00)); e.push_back(LU);
        s.push_back(mk(5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00)); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rd_zero step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_redirect();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b01)); e.push_back(FLUSH_RUN);
        s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b11)); e.push_back(FLUSH_RUN);
        s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00)); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL redirect step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_md();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        stimT nop;
        nop = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00);
        s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00)); e.push_back(IDLE);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00)); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDD);
        s.push_back(nop); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL md_latency step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_lu_md();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        stimT nop;
        nop = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 2'b00)); e.push_back(LU);
        s.push_back(mk(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00)); e.push_back(IDLE);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDD);
        s.push_back(nop); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL lu_md step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_back_to_back();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        stimT nop;
        stimT md;
        nop = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00);
        md  = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00);
        s.push_back(md);  e.push_back(IDLE);
        s.push_back(md);  e.push_back(MDW);
        s.push_back(md);  e.push_back(MDW);
        s.push_back(md);  e.push_back(MDW);
        s.push_back(md);  e.push_back(MDD);
        s.push_back(md);  e.push_back(IDLE);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDD);
        s.push_back(nop); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_md_abort();
        stimT s[$];
        logic [6:0] e[$];
        logic [6:0] got;
        logic [6:0] want;
        stimT nop;
        stimT md;
        nop = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00);
        md  = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00);
        s.push_back(md);  e.push_back(IDLE);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10)); e.push_back(FLUSH_MDW);
        s.push_back(nop); e.push_back(IDLE);
        s.push_back(md);  e.push_back(IDLE);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(nop); e.push_back(MDW);
        s.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b01)); e.push_back(FLUSH_MDD);
        s.push_back(nop); e.push_back(IDLE);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            expQ.push_back(e[i]);
            @(negedge clk);
            got = observed();
            want = expQ.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL md_abort step %0d: got %b expected %b", i, got, want);
            end
            tally(want);
        end
    endtask

    task automatic test_reset_mid_md();
        logic [6:0] got;
        drive(mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_start: got %b expected %b", got, IDLE);
        end
        drive(mk(5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== MDW) begin
            errors++;
            $display("FAIL reset_mid_wait: got %b expected %b", got, MDW);
        end
        #2;
        rst = 1'b0;
        expStall = '0;
        expFlush = '0;
        #1;
        got = observed();
        checks++;
        if (got !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected %b", got, IDLE);
        end
        checks++;
        if ((hif.stall_cnt !== '0) || (hif.flush_cnt !== '0)) begin
            errors++;
            $display("FAIL reset_mid_counters: got %0d/%0d expected 0/0", hif.stall_cnt, hif.flush_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== IDLE) begin
                errors++;
                $display("FAIL reset_mid_after step %0d: got %b expected %b", i, got, IDLE);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_perf_counters();
        logic [6:0] got;
        logic [CNT_W-1:0] wantStall;
        logic [CNT_W-1:0] wantFlush;
        drive(mk(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 2'b00));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== LU) begin
            errors++;
            $display("FAIL perf_lu: got %b expected %b", got, LU);
        end
        tally(LU);
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10));
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== FLUSH_RUN) begin
            errors++;
            $display("FAIL perf_flush: got %b expected %b", got, FLUSH_RUN);
        end
        tally(FLUSH_RUN);
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00));
        @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
        wantStall = expStall;
        wantFlush = expFlush;
`else
        wantStall = '0;
        wantFlush = '0;
`endif
        checks++;
        if (hif.stall_cnt !== wantStall) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", hif.stall_cnt, wantStall);
        end
        checks++;
        if (hif.flush_cnt !== wantFlush) begin
            errors++;
            $display("FAIL flush_cnt: got %0d expected %0d", hif.flush_cnt, wantFlush);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect();
        test_md();
        test_lu_md();
        test_back_to_back();
        test_md_abort();
        test_reset_mid_md();
        test_perf_counters();
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
